// File: rtl/simt_store_writeback_stage_if.sv
// Bundle of every handshake/bus channel around the SIMT store/writeback stage.
// master = the stage itself, slave = its environment (execute, memory, regfile, fetch).
interface simt_store_writeback_stage_if #(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned REG_W     = 5
);
  localparam int unsigned LW = NUM_LANES * XLEN;

  logic                 ex_valid;
  logic                 ex_ready;
  logic [2:0]           ex_opcode;
  logic [NUM_LANES-1:0] ex_exec_mask;
  logic [NUM_LANES-1:0] ex_mask_true;
  logic [NUM_LANES-1:0] ex_mask_false;
  logic [REG_W-1:0]     ex_dest_reg;
  logic [ADDR_W-1:0]    ex_dest_pc;
  logic [ADDR_W-1:0]    ex_src_pc;
  logic [LW-1:0]        ex_dest_vec;
  logic [LW-1:0]        ex_src_vec;
  logic                 ex_store_to_pc;

  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic                 mem_req_write;
  logic [LW-1:0]        mem_req_addr;
  logic [LW-1:0]        mem_req_wdata;
  logic [NUM_LANES-1:0] mem_req_mask;
  logic [15:0]          mem_req_id;
  logic                 mem_rsp_valid;
  logic                 mem_rsp_ready;
  logic [LW-1:0]        mem_rsp_data;

  logic                 rf_we;
  logic [REG_W-1:0]     rf_waddr;
  logic [LW-1:0]        rf_wdata;
  logic [NUM_LANES-1:0] rf_wmask;

  logic                 fetch_valid;
  logic                 fetch_ready;
  logic [ADDR_W-1:0]    fetch_pc;
  logic [NUM_LANES-1:0] fetch_mask;

  logic                 halted;
  logic                 div_overflow;
  logic                 illegal_op;
  logic                 stat_diverge;
  logic                 stat_mem_wait;

  modport master (
    input  ex_valid, ex_opcode, ex_exec_mask, ex_mask_true, ex_mask_false, ex_dest_reg,
           ex_dest_pc, ex_src_pc, ex_dest_vec, ex_src_vec, ex_store_to_pc,
           mem_req_ready, mem_rsp_valid, mem_rsp_data, fetch_ready,
    output ex_ready, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_mask,
           mem_req_id, mem_rsp_ready, rf_we, rf_waddr, rf_wdata, rf_wmask,
           fetch_valid, fetch_pc, fetch_mask, halted, div_overflow, illegal_op,
           stat_diverge, stat_mem_wait
  );

  modport slave (
    output ex_valid, ex_opcode, ex_exec_mask, ex_mask_true, ex_mask_false, ex_dest_reg,
           ex_dest_pc, ex_src_pc, ex_dest_vec, ex_src_vec, ex_store_to_pc,
           mem_req_ready, mem_rsp_valid, mem_rsp_data, fetch_ready,
    input  ex_ready, mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_mask,
           mem_req_id, mem_rsp_ready, rf_we, rf_waddr, rf_wdata, rf_wmask,
           fetch_valid, fetch_pc, fetch_mask, halted, div_overflow, illegal_op,
           stat_diverge, stat_mem_wait
  );
endinterface

// File: rtl/simt_store_writeback_stage.sv
// Last SIMT pipeline stage: retires one execute packet at a time (writeback, load/store,
// jump/branch redirect, halt) and owns the {pc, mask} divergence stack.
module simt_store_writeback_stage #(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned DIV_DEPTH = 8,
  parameter logic [15:0] BUS_ID    = 16'd0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  simt_store_writeback_stage_if.master  io_bus
);
  localparam int unsigned LW    = NUM_LANES * XLEN;
  localparam int unsigned PTR_W = $clog2(DIV_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DIV_DEPTH);

  typedef enum logic [2:0] {
    OP_NOP, OP_JMP, OP_CJMP, OP_LOAD, OP_STORE, OP_STORE_VALUE, OP_HALT, OP_ILLEGAL
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_MEM_REQ, S_MEM_WAIT, S_WB, S_FETCH, S_HALTED
  } state_e;

  state_e               r_state;
  op_e                  r_op;
  logic [NUM_LANES-1:0] r_exec_mask, r_mask_true, r_mask_false;
  logic [REG_W-1:0]     r_dest_reg;
  logic [ADDR_W-1:0]    r_dest_pc, r_src_pc;
  logic [LW-1:0]        r_dest_vec, r_src_vec;
  logic                 r_store_to_pc;

  logic                 r_ex_ready;
  logic                 r_mem_req_valid, r_mem_req_write, r_mem_rsp_ready;
  logic [LW-1:0]        r_mem_req_addr, r_mem_req_wdata;
  logic [NUM_LANES-1:0] r_mem_req_mask;
  logic [15:0]          r_mem_req_id;
  logic                 r_rf_we;
  logic [REG_W-1:0]     r_rf_waddr;
  logic [LW-1:0]        r_rf_wdata;
  logic [NUM_LANES-1:0] r_rf_wmask;
  logic                 r_fetch_valid;
  logic [ADDR_W-1:0]    r_fetch_pc;
  logic [NUM_LANES-1:0] r_fetch_mask;
  logic                 r_halted, r_div_overflow, r_illegal_op, r_stat_diverge, r_stat_mem_wait;

  logic [ADDR_W-1:0]    r_stk_pc   [DIV_DEPTH];
  logic [NUM_LANES-1:0] r_stk_mask [DIV_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;

  logic                 w_split, w_push;
  logic [PTR_W-1:0]     w_top;

  assign w_split = (|r_mask_true) && (|r_mask_false);
  assign w_push  = (r_state == S_DECODE) && (r_op == OP_CJMP) && w_split && (r_count != FULL);
  // r_wr_ptr is the next free slot; the most recent entry sits just below it
  assign w_top   = r_wr_ptr - PTR_W'(1);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_stk_pc[r_wr_ptr]   <= r_dest_pc;
      r_stk_mask[r_wr_ptr] <= r_mask_true;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_op            <= OP_NOP;
      r_exec_mask     <= '0;
      r_mask_true     <= '0;
      r_mask_false    <= '0;
      r_dest_reg      <= '0;
      r_dest_pc       <= '0;
      r_src_pc        <= '0;
      r_dest_vec      <= '0;
      r_src_vec       <= '0;
      r_store_to_pc   <= 1'b0;
      r_ex_ready      <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_mem_req_write <= 1'b0;
      r_mem_req_addr  <= '0;
      r_mem_req_wdata <= '0;
      r_mem_req_mask  <= '0;
      r_mem_req_id    <= '0;
      r_mem_rsp_ready <= 1'b0;
      r_rf_we         <= 1'b0;
      r_rf_waddr      <= '0;
      r_rf_wdata      <= '0;
      r_rf_wmask      <= '0;
      r_fetch_valid   <= 1'b0;
      r_fetch_pc      <= '0;
      r_fetch_mask    <= '0;
      r_halted        <= 1'b0;
      r_div_overflow  <= 1'b0;
      r_illegal_op    <= 1'b0;
      r_stat_diverge  <= 1'b0;
      r_stat_mem_wait <= 1'b0;
      r_wr_ptr        <= '0;
      r_count         <= '0;
    end else begin
      r_rf_we         <= 1'b0;
      r_stat_diverge  <= 1'b0;
      r_stat_mem_wait <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (io_bus.ex_valid) begin
            r_op          <= op_e'(io_bus.ex_opcode);
            r_exec_mask   <= io_bus.ex_exec_mask;
            r_mask_true   <= io_bus.ex_mask_true;
            r_mask_false  <= io_bus.ex_mask_false;
            r_dest_reg    <= io_bus.ex_dest_reg;
            r_dest_pc     <= io_bus.ex_dest_pc;
            r_src_pc      <= io_bus.ex_src_pc;
            r_dest_vec    <= io_bus.ex_dest_vec;
            r_src_vec     <= io_bus.ex_src_vec;
            r_store_to_pc <= io_bus.ex_store_to_pc;
            r_ex_ready    <= 1'b0;
            r_state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          // Single-cycle ops fall back to idle; longer ones override below
          r_state    <= S_IDLE;
          r_ex_ready <= 1'b1;
          unique case (r_op)
            OP_NOP: begin end
            OP_ILLEGAL: r_illegal_op <= 1'b1;
            OP_STORE_VALUE: begin
              r_rf_we    <= 1'b1;
              r_rf_waddr <= r_dest_reg;
              r_rf_wdata <= r_src_vec;
              r_rf_wmask <= r_exec_mask;
            end
            OP_STORE, OP_LOAD: begin
              r_mem_req_valid <= 1'b1;
              r_mem_req_write <= (r_op == OP_STORE);
              r_mem_req_addr  <= (r_op == OP_STORE) ? r_dest_vec : r_src_vec;
              r_mem_req_wdata <= r_src_vec;
              r_mem_req_mask  <= r_exec_mask;
              r_mem_req_id    <= BUS_ID;
              r_ex_ready      <= 1'b0;
              r_state         <= S_MEM_REQ;
            end
            OP_JMP: begin
              r_fetch_valid <= 1'b1;
              r_fetch_pc    <= r_dest_pc;
              r_fetch_mask  <= r_exec_mask;
              r_ex_ready    <= 1'b0;
              r_state       <= S_FETCH;
            end
            OP_CJMP: begin
              r_fetch_valid <= 1'b1;
              r_ex_ready    <= 1'b0;
              r_state       <= S_FETCH;
              if (w_split) begin
                r_stat_diverge <= 1'b1;
                if (r_count == FULL) begin
                  r_div_overflow <= 1'b1;
                end else begin
                  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                  r_count  <= r_count + CNT_W'(1);
                end
                r_fetch_pc   <= r_src_pc;
                r_fetch_mask <= r_mask_false;
              end else if (|r_mask_true) begin
                r_fetch_pc   <= r_dest_pc;
                r_fetch_mask <= r_mask_true;
              end else begin
                r_fetch_pc   <= r_src_pc;
                r_fetch_mask <= r_mask_false;
              end
            end
            OP_HALT: begin
              r_ex_ready <= 1'b0;
              if (r_count != '0) begin
                r_fetch_valid <= 1'b1;
                r_fetch_pc    <= r_stk_pc[w_top];
                r_fetch_mask  <= r_stk_mask[w_top];
                r_wr_ptr      <= w_top;
                r_count       <= r_count - CNT_W'(1);
                r_state       <= S_FETCH;
              end else begin
                r_halted <= 1'b1;
                r_state  <= S_HALTED;
              end
            end
            default: begin end
          endcase
        end
        S_MEM_REQ: begin
          if (io_bus.mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            if (r_mem_req_write) begin
              r_ex_ready <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_mem_rsp_ready <= 1'b1;
              r_state         <= S_MEM_WAIT;
            end
          end
        end
        S_MEM_WAIT: begin
          if (io_bus.mem_rsp_valid) begin
            r_mem_rsp_ready <= 1'b0;
            r_rf_we         <= 1'b1;
            r_rf_waddr      <= r_dest_reg;
            r_rf_wdata      <= io_bus.mem_rsp_data;
            r_rf_wmask      <= r_exec_mask;
            r_state         <= S_WB;
          end else begin
            r_stat_mem_wait <= 1'b1;
          end
        end
        S_WB: begin
          if (r_store_to_pc) begin
            r_fetch_valid <= 1'b1;
            r_fetch_pc    <= r_rf_wdata[ADDR_W-1:0];
            r_fetch_mask  <= r_exec_mask;
            r_state       <= S_FETCH;
          end else begin
            r_ex_ready <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        S_FETCH: begin
          if (io_bus.fetch_ready) begin
            r_fetch_valid <= 1'b0;
            r_ex_ready    <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.ex_ready      = r_ex_ready;
  assign io_bus.mem_req_valid = r_mem_req_valid;
  assign io_bus.mem_req_write = r_mem_req_write;
  assign io_bus.mem_req_addr  = r_mem_req_addr;
  assign io_bus.mem_req_wdata = r_mem_req_wdata;
  assign io_bus.mem_req_mask  = r_mem_req_mask;
  assign io_bus.mem_req_id    = r_mem_req_id;
  assign io_bus.mem_rsp_ready = r_mem_rsp_ready;
  assign io_bus.rf_we         = r_rf_we;
  assign io_bus.rf_waddr      = r_rf_waddr;
  assign io_bus.rf_wdata      = r_rf_wdata;
  assign io_bus.rf_wmask      = r_rf_wmask;
  assign io_bus.fetch_valid   = r_fetch_valid;
  assign io_bus.fetch_pc      = r_fetch_pc;
  assign io_bus.fetch_mask    = r_fetch_mask;
  assign io_bus.halted        = r_halted;
  assign io_bus.div_overflow  = r_div_overflow;
  assign io_bus.illegal_op    = r_illegal_op;
  assign io_bus.stat_diverge  = r_stat_diverge;
  assign io_bus.stat_mem_wait = r_stat_mem_wait;
endmodule
